// File: rtl/regfile_pkg.sv
// Shared defaults and index helpers for the scoreboarded register file.
package regfile_pkg;

  function automatic int calcAw(input int numRegs);
    return (numRegs <= 2) ? 1 : $clog2(numRegs);
  endfunction

  localparam int DEFAULT_WIDTH    = 32;
  localparam int DEFAULT_NUM_REGS = 32;
  localparam int DEFAULT_AW       = calcAw(DEFAULT_NUM_REGS);

  typedef logic [DEFAULT_AW-1:0] regIdx_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/write-back bus of the register file: the master drives addresses and strobes, the slave returns data and scoreboard state.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int AW       = calcAw(NUM_REGS)
);
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [WIDTH-1:0]    wr_data;
  logic [AW-1:0]       rd_addr_0;
  logic [WIDTH-1:0]    rd_data_0;
  logic [AW-1:0]       rd_addr_1;
  logic [WIDTH-1:0]    rd_data_1;
  logic [AW-1:0]       dbg_addr;
  logic [WIDTH-1:0]    dbg_data;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                iss_rd_we;
  logic                iss_ready;
  logic [NUM_REGS-1:0] busy_vec;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_0, rd_addr_1, dbg_addr,
           iss_valid, iss_rd, iss_rd_we,
    input  rd_data_0, rd_data_1, dbg_data, iss_ready, busy_vec
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_0, rd_addr_1, dbg_addr,
           iss_valid, iss_rd, iss_rd_we,
    output rd_data_0, rd_data_1, dbg_data, iss_ready, busy_vec
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy tracking and issue gating; REGFILE_BYPASS_EN lets a write-back hide its own busy bit from the readiness check.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int ZERO_REG = 1,
  parameter int AW       = calcAw(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_wrEn,
  input  logic [AW-1:0]       i_wrAddr,
  input  logic [AW-1:0]       i_rdAddr0,
  input  logic [AW-1:0]       i_rdAddr1,
  input  logic                i_issValid,
  input  logic [AW-1:0]       i_issRd,
  input  logic                i_issRdWe,
  output logic                o_issReady,
  output logic [NUM_REGS-1:0] o_busyVec
);
  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busyView;
  logic [NUM_REGS-1:0] w_busyNext;
  logic                w_issFire;
  logic                w_setOk;

  always_comb begin
    w_busyView = r_busy;
`ifdef REGFILE_BYPASS_EN
    if (i_wrEn) w_busyView[i_wrAddr] = 1'b0;
`endif
  end

  assign o_issReady = !(w_busyView[i_rdAddr0] | w_busyView[i_rdAddr1] |
                        (i_issRdWe & w_busyView[i_issRd]));
  assign w_issFire  = i_issValid & o_issReady;
  assign w_setOk    = i_issRdWe && !((ZERO_REG != 0) && (i_issRd == '0));

  // Clear is applied before set so a new owner issuing on the write-back edge keeps the register busy.
  always_comb begin
    w_busyNext = r_busy;
    if (i_wrEn) w_busyNext[i_wrAddr] = 1'b0;
    if (w_issFire && w_setOk) w_busyNext[i_issRd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) r_busy <= '0;
    else        r_busy <= w_busyNext;
  end

  assign o_busyVec = r_busy;
endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with busy scoreboard; define REGFILE_BYPASS_EN for write-through forwarding on all read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int ZERO_REG = 1
) (
  input  logic        clk,
  input  logic        reset,
  regfile_sb_if.slave bus
);
  localparam int AW = calcAw(NUM_REGS);

  logic [WIDTH-1:0] r_regs [NUM_REGS];
  logic             w_wrKeep;
  logic [AW-1:0]    w_wrAddr;
  logic [WIDTH-1:0] w_wrData;

  assign w_wrAddr = bus.wr_addr;
  assign w_wrData = bus.wr_data;
  assign w_wrKeep = bus.wr_en && !((ZERO_REG != 0) && (bus.wr_addr == '0));

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wrKeep) begin
      r_regs[w_wrAddr] <= w_wrData;
    end
  end

  function automatic logic [WIDTH-1:0] readPort(input logic [AW-1:0] addr);
    logic [WIDTH-1:0] v;
    if ((ZERO_REG != 0) && (addr == '0)) v = '0;
`ifdef REGFILE_BYPASS_EN
    else if (w_wrKeep && (addr == w_wrAddr)) v = w_wrData;
`endif
    else v = r_regs[addr];
    return v;
  endfunction

  assign bus.rd_data_0 = readPort(bus.rd_addr_0);
  assign bus.rd_data_1 = readPort(bus.rd_addr_1);
  assign bus.dbg_data  = readPort(bus.dbg_addr);

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .i_wrEn     (bus.wr_en),
    .i_wrAddr   (bus.wr_addr),
    .i_rdAddr0  (bus.rd_addr_0),
    .i_rdAddr1  (bus.rd_addr_1),
    .i_issValid (bus.iss_valid),
    .i_issRd    (bus.iss_rd),
    .i_issRdWe  (bus.iss_rd_we),
    .o_issReady (bus.iss_ready),
    .o_busyVec  (bus.busy_vec)
  );
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed hazard scenarios, randomized traffic against a register/busy model, and an 8x16 ZERO_REG=0 instance.
module tb_regfile_sb;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   compared = 0;
  int   mismatched = 0;
  bit   modelValid = 1'b0;

  logic [31:0] mRegs [32];
  logic        mBusy [32];

  always #5 clk = ~clk;

  regfile_sb_if #(.WIDTH(32), .NUM_REGS(32)) bus ();
  regfile_sb #(.WIDTH(32), .NUM_REGS(32), .ZERO_REG(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  regfile_sb_if #(.WIDTH(16), .NUM_REGS(8)) sbus ();
  regfile_sb #(.WIDTH(16), .NUM_REGS(8), .ZERO_REG(0)) sdut (
    .clk   (clk),
    .reset (reset),
    .bus   (sbus)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit wrEn, input regIdx_t wrAddr, input logic [31:0] wrData,
                               input regIdx_t ra0, input regIdx_t ra1, input regIdx_t dbg,
                               input bit issValid, input regIdx_t issRd, input bit issWe);
    bus.wr_en     = wrEn;
    bus.wr_addr   = wrAddr;
    bus.wr_data   = wrData;
    bus.rd_addr_0 = ra0;
    bus.rd_addr_1 = ra1;
    bus.dbg_addr  = dbg;
    bus.iss_valid = issValid;
    bus.iss_rd    = issRd;
    bus.iss_rd_we = issWe;
  endtask

  // Reference view: stored value, or the in-flight write-back when forwarding is built in.
  function automatic logic [31:0] mRead(input regIdx_t a);
    if (a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (bus.wr_en && a == bus.wr_addr) return bus.wr_data;
`endif
    return mRegs[a];
  endfunction

  function automatic logic mBusyView(input regIdx_t a);
`ifdef REGFILE_BYPASS_EN
    if (bus.wr_en && a == bus.wr_addr) return 1'b0;
`endif
    return mBusy[a];
  endfunction

  function automatic logic mReady();
    return !(mBusyView(bus.rd_addr_0) || mBusyView(bus.rd_addr_1) ||
             (bus.iss_rd_we && mBusyView(bus.iss_rd)));
  endfunction

  function automatic logic [31:0] mBusyVec();
    logic [31:0] v = '0;
    for (int i = 0; i < 32; i++) v[i] = mBusy[i];
    return v;
  endfunction

  task automatic checkAll(input string tag);
    checkOutput({tag, ".rd0"},   bus.rd_data_0, mRead(bus.rd_addr_0));
    checkOutput({tag, ".rd1"},   bus.rd_data_1, mRead(bus.rd_addr_1));
    checkOutput({tag, ".dbg"},   bus.dbg_data,  mRead(bus.dbg_addr));
    checkOutput({tag, ".ready"}, bus.iss_ready, mReady());
    checkOutput({tag, ".busy"},  bus.busy_vec,  mBusyVec());
  endtask

  // Settle, compare against the model, advance the model by one edge, then clock the DUT.
  task automatic tick();
    logic fire;
    #1;
    if (modelValid) checkAll("cyc");
    fire = bus.iss_valid && mReady();
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        mRegs[i] = '0;
        mBusy[i] = 1'b0;
      end
      modelValid = 1'b1;
    end else begin
      if (bus.wr_en && bus.wr_addr != 0) mRegs[bus.wr_addr] = bus.wr_data;
      if (bus.wr_en) mBusy[bus.wr_addr] = 1'b0;
      if (fire && bus.iss_rd_we && bus.iss_rd != 0) mBusy[bus.iss_rd] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] sData;
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    sbus.wr_en = 0; sbus.wr_addr = 0; sbus.wr_data = 0;
    sbus.rd_addr_0 = 0; sbus.rd_addr_1 = 0; sbus.dbg_addr = 0;
    sbus.iss_valid = 0; sbus.iss_rd = 0; sbus.iss_rd_we = 0;
    @(negedge clk);
    tick();
    reset = 1'b1;

    applyStimulus(0, 0, 0, 5, 0, 0, 0, 0, 0);
    #1;
    checkOutput("reset.busy", bus.busy_vec, 0);
    checkOutput("reset.rd0", bus.rd_data_0, 0);
    checkOutput("reset.ready", bus.iss_ready, 1);

    applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 5, 0, 5, 0, 0, 0);
    #1;
    checkOutput("wr5.rd0", bus.rd_data_0, 32'hDEADBEEF);
    checkOutput("wr5.dbg", bus.dbg_data, 32'hDEADBEEF);

    applyStimulus(1, 0, 32'h1234, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("zero.rd0", bus.rd_data_0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("zero.busy", bus.busy_vec, 0);

    applyStimulus(0, 0, 0, 0, 0, 0, 1, 7, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 7, 0, 0, 0, 0);
    #1;
    checkOutput("raw.busy", bus.busy_vec, 32'h80);
    checkOutput("raw.stall", bus.iss_ready, 0);
    applyStimulus(1, 7, 32'h55, 0, 7, 0, 0, 0, 0);
    #1;
`ifdef REGFILE_BYPASS_EN
    checkOutput("raw.wbReady", bus.iss_ready, 1);
    checkOutput("raw.wbFwd", bus.rd_data_1, 32'h55);
`else
    checkOutput("raw.wbReady", bus.iss_ready, 0);
    checkOutput("raw.wbStored", bus.rd_data_1, 0);
`endif
    tick();
    applyStimulus(0, 0, 0, 0, 7, 0, 0, 0, 0);
    #1;
    checkOutput("raw.afterReady", bus.iss_ready, 1);
    checkOutput("raw.afterRd1", bus.rd_data_1, 32'h55);

    applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, 1);
    tick();
    applyStimulus(1, 9, 32'hA5A5, 0, 0, 9, 1, 9, 1);
    #1;
`ifdef REGFILE_BYPASS_EN
    checkOutput("coll.ready", bus.iss_ready, 1);
`else
    checkOutput("coll.ready", bus.iss_ready, 0);
`endif
    tick();
    applyStimulus(0, 0, 0, 0, 0, 9, 0, 0, 0);
    #1;
    checkOutput("coll.data", bus.dbg_data, 32'hA5A5);
`ifdef REGFILE_BYPASS_EN
    checkOutput("coll.busy", bus.busy_vec, 32'h200);
`else
    checkOutput("coll.busy", bus.busy_vec, 0);
`endif
    applyStimulus(1, 9, 32'hA5A5, 0, 0, 9, 0, 0, 0);
    tick();

    applyStimulus(0, 0, 0, 0, 0, 0, 1, 3, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 4, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("rst.busyPre", bus.busy_vec, 32'h18);
    reset = 1'b0;
    applyStimulus(1, 3, 32'h77, 3, 4, 3, 0, 4, 1);
    #1;
    checkOutput("rst.readyPre", bus.iss_ready, 0);
    tick();
    reset = 1'b1;
    applyStimulus(0, 0, 0, 3, 4, 3, 0, 4, 1);
    #1;
    checkOutput("rst.busy", bus.busy_vec, 0);
    checkOutput("rst.reg3", bus.dbg_data, 0);
    checkOutput("rst.ready", bus.iss_ready, 1);

    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 63) != 0);
      applyStimulus(1'($urandom_range(0, 1)), regIdx_t'($urandom_range(0, 15)), $urandom,
                    regIdx_t'($urandom_range(0, 15)), regIdx_t'($urandom_range(0, 15)),
                    regIdx_t'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    regIdx_t'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      tick();
    end
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 8; i++) begin
      sbus.wr_en   = 1'b1;
      sbus.wr_addr = 3'(i);
      sbus.wr_data = 16'h1000 + 16'(i) * 16'h0111;
      tick();
    end
    sbus.wr_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sbus.rd_addr_0 = 3'(i);
      sbus.rd_addr_1 = 3'(7 - i);
      sbus.dbg_addr  = 3'(i);
      #1;
      sData = 16'h1000 + 16'(i) * 16'h0111;
      checkOutput("sweep.rd0", sbus.rd_data_0, sData);
      checkOutput("sweep.dbg", sbus.dbg_data, sData);
      sData = 16'h1000 + 16'(7 - i) * 16'h0111;
      checkOutput("sweep.rd1", sbus.rd_data_1, sData);
    end
    sbus.rd_addr_0 = 0;
    sbus.rd_addr_1 = 0;
    sbus.iss_valid = 1'b1;
    sbus.iss_rd    = 0;
    sbus.iss_rd_we = 1'b1;
    tick();
    sbus.iss_valid = 1'b0;
    #1;
    checkOutput("sweep.busy0", sbus.busy_vec, 8'h01);
    checkOutput("sweep.stall0", sbus.iss_ready, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
